// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM controller/arbiter for pipeline (P) and loader (L) ports
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_ready,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_ack,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [31:0]       stat_stall_cycles,
    output logic [31:0]       stat_l_grants
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
    logic                grant_l;
    logic                acc_last;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_cnt_d = acc_cnt_q;
        starve_d  = starve_q;
        p_rdata_d = p_rdata_q;
        l_rdata_d = l_rdata_q;
        // L only beats a concurrent P request once it has lost MAX_WAIT times in a row
        grant_l   = l_req && (!p_req || (starve_q == SW'(MAX_WAIT)));
        acc_last  = (acc_cnt_q == CNT_W'(MEM_LAT - 1));

        case (state_q)
            S_IDLE: begin
                if (p_req || l_req) begin
                    owner_d   = grant_l;
                    we_d      = grant_l ? l_we    : p_we;
                    addr_d    = grant_l ? l_addr  : p_addr;
                    wdata_d   = grant_l ? l_wdata : p_wdata;
                    acc_cnt_d = '0;
                    state_d   = S_ACCESS;
                    if (grant_l) begin
                        starve_d = '0;
                    end else if (l_req && (starve_q != SW'(MAX_WAIT))) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                acc_cnt_d = acc_cnt_q + 1'b1;
                if (acc_last) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_q) begin
                            l_rdata_d = ram_rdata;
                        end else begin
                            p_rdata_d = ram_rdata;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            acc_cnt_q <= '0;
            starve_q  <= '0;
            p_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            acc_cnt_q <= acc_cnt_d;
            starve_q  <= starve_d;
            p_rdata_q <= p_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // Strobes decode straight from state so a reset kills them on the very next edge
    assign ram_we    = (state_q == S_ACCESS) && we_q && (acc_cnt_q == '0);
    assign ram_re    = (state_q == S_ACCESS) && !we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign p_ready   = (state_q == S_RESP) && !owner_q;
    assign l_ack     = (state_q == S_RESP) && owner_q;
    assign p_rdata   = p_rdata_q;
    assign l_rdata   = l_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] lgr_q, lgr_d;

    always_comb begin
        stall_d = stall_q;
        lgr_d   = lgr_q;
        if (p_req && !p_ready) begin
            stall_d = stall_q + 32'd1;
        end
        if ((state_q == S_IDLE) && grant_l) begin
            lgr_d = lgr_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            lgr_q   <= '0;
        end else begin
            stall_q <= stall_d;
            lgr_q   <= lgr_d;
        end
    end

    assign stat_stall_cycles = stall_q;
    assign stat_l_grants     = lgr_q;
`else
    assign stat_stall_cycles = 32'd0;
    assign stat_l_grants     = 32'd0;
`endif

endmodule
